rr_burst_arbiter: RTL and testbench
===================================

# rr_burst_arbiter

Round-robin arbiter that shares one burst-counted resource between up to four requesters. It grants one requester at a time for a bounded burst of 1 to 4 beats, tracked by an internal 2-bit beat counter. It releases early if the owner drops its request, then rotates priority. It sits in front of the team's 2-bit counter datapath and sequences which client drives it.

## Interface
- N, default 4: number of requesters; legal range 2..4.
- BURST_LEN, default 4: maximum beats per grant; legal range 1..4.
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  N  per-requester request level, sampled on the rising edge of clk.
- grant  output  N  one-hot grant, registered; all zero when no owner.
- grant_id  output  2  index of current owner; 0 when idle.
- beat  output  2  beats already completed in the current grant (0 on the first granted cycle).
- busy  output  1  high while any grant bit is high.

## Operation
- FSM states:
  - IDLE: no owner.
  - GRANT: owner holds the resource.
  - GAP: one-cycle turnaround; present only when ARB_GAP_EN is defined.
- Round-robin pointer ptr is 2 bits and resets to 0. Arbitration searches req starting at index ptr, wrapping modulo N. The first set bit wins. On a win, ptr is set to (winner+1) mod N.
- IDLE: if any req is set at an edge, enter GRANT. grant[winner]=1, grant_id=winner, beat=0. Otherwise stay in IDLE with all outputs 0.
- GRANT, at each edge, evaluate the end condition: req[grant_id]==0, or beat==BURST_LEN-1.
  - No end: stay in GRANT and increment beat by 1. beat never wraps within a grant.
  - End, with ARB_GAP_EN: go to GAP. grant=0, beat=0.
  - End, without ARB_GAP_EN: arbitrate on the same edge using the updated ptr.
    - If a winner exists, stay in GRANT with the new owner and beat=0.
    - If there is no winner, go to IDLE.
- A lone persistent requester is re-granted after its burst ends, because the search wraps back to it.
- GAP: after one cycle, arbitrate. Go to GRANT if there is a winner, else IDLE.
- Requests from non-owners never affect the current grant.
- Reset (any time, including mid-burst) drives:
  - state=IDLE, grant=0, grant_id=0, beat=0, busy=0, ptr=0;
  - all outputs at these values immediately and asynchronously.
- Out-of-range parameters are not supported. No runtime checking is done.

## Timing
- Request-to-grant latency from IDLE is 1 cycle: req rising before edge k gives grant high after edge k.
- Maximum grant duration is BURST_LEN cycles.
- Early release: req[owner] sampled low at an edge clears grant at that same edge. The last beat value is not counted further.
- Back-to-back handover without ARB_GAP_EN: zero idle cycles. grant switches one-hot to one-hot on a single edge.
- Handover with ARB_GAP_EN: exactly one cycle with grant=0 between owners.
- Output relationships:
  - busy equals OR of grant, registered in the same cycle.
  - beat and grant_id change only on edges where the state or owner changes or a beat completes.
- Idle output values: grant_id=0 and beat=0 whenever grant==0.

## Configuration
- Macro ARB_GAP_EN.
  - Defined: the GAP state is compiled in. Every grant end is followed by one idle turnaround cycle before the next grant.
  - Not defined: the GAP state is absent and handover is back-to-back.
- The macro does not change arbitration order, burst length or reset behaviour.

## Test plan
- Reset mid-burst: N=4, BURST_LEN=4, req=0001, grant at beat=2; pulse rst low. Response: grant=0000, beat=0, busy=0 immediately. After release with req still 0001, grant=0001 one edge later.
- Full burst and re-grant: req=0001 held. Response: grant=0001 for 4 cycles with beat 0,1,2,3.
  - Without ARB_GAP_EN: re-granted with beat=0 on the next edge.
  - With ARB_GAP_EN: one cycle of grant=0000 first.
- Round-robin rotation: req=1111 held, BURST_LEN=2, no gap. Response: grant_id sequence 0,0,1,1,2,2,3,3,0, with no idle cycles.
- Early release: owner 2 with req=0100 drops req at beat=1 while req=0001 is pending. Response: the next edge gives grant=0001, grant_id=0, beat=0 (no gap), because ptr=3 and the search wraps to 0.
- BURST_LEN=1 with N=2 and req=11. Response: grant alternates 01,10,01 every cycle. beat stays 0 throughout.
- Idle behaviour: req=0000 for 10 cycles after reset. Response: grant=0, grant_id=0, beat=0, busy=0 throughout.

Source files
------------

// File: rtl/rr_burst_arbiter_if.sv
// Request/grant bundle between up to four requesters and rr_burst_arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface rr_burst_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0] req;
  logic [N-1:0] grant;
  logic [1:0]   grant_id;
  logic [1:0]   beat;
  logic         busy;

  modport master (output req, input grant, grant_id, beat, busy);
  modport slave  (input req, output grant, grant_id, beat, busy);
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: one owner at a time for up to BURST_LEN beats.
// Define ARB_GAP_EN to insert a one-cycle GAP turnaround between grants.
module rr_burst_arbiter #(
  parameter int N         = 4,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  rr_burst_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
`ifdef ARB_GAP_EN
  localparam logic [1:0] ST_GAP   = 2'd2;
`endif
  localparam logic [1:0]   LAST_BEAT = 2'(BURST_LEN - 1);
  localparam logic [N-1:0] ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [1:0]   ptr_q, ptr_d;
  logic [1:0]   owner_q, owner_d;
  logic [1:0]   beat_q, beat_d;
  logic [N-1:0] grant_q, grant_d;
  logic         busy_q, busy_d;

  logic         found;
  logic [1:0]   winner;
  logic [1:0]   win_next;
  logic [2:0]   idx;
  logic         burst_end;
  logic         take;

  // Search req from ptr upward, wrapping modulo N; first set bit wins.
  always_comb begin
    found  = 1'b0;
    winner = 2'd0;
    idx    = 3'd0;
    for (int i = 0; i < N; i++) begin
      idx = 3'(ptr_q) + 3'(i);
      if (idx >= 3'(N)) idx = idx - 3'(N);
      if (!found && bus.req[idx]) begin
        found  = 1'b1;
        winner = idx[1:0];
      end
    end
  end

  assign win_next  = (winner == 2'(N - 1)) ? 2'd0 : winner + 2'd1;
  assign burst_end = !bus.req[owner_q] || (beat_q == LAST_BEAT);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    beat_d  = beat_q;
    grant_d = grant_q;
    take    = 1'b0;
    case (state_q)
      ST_GRANT: begin
        if (!burst_end) begin
          beat_d = beat_q + 2'd1;
        end else begin
          owner_d = 2'd0;
          beat_d  = 2'd0;
          grant_d = '0;
`ifdef ARB_GAP_EN
          state_d = ST_GAP;
`else
          state_d = ST_IDLE;
          take    = found;
`endif
        end
      end
`ifdef ARB_GAP_EN
      ST_GAP: begin
        state_d = ST_IDLE;
        take    = found;
      end
`endif
      default: begin
        state_d = ST_IDLE;
        owner_d = 2'd0;
        beat_d  = 2'd0;
        grant_d = '0;
        take    = found;
      end
    endcase
    // A new owner always starts at beat 0 and moves the pointer past itself.
    if (take) begin
      state_d = ST_GRANT;
      owner_d = winner;
      beat_d  = 2'd0;
      grant_d = ONE_HOT0 << winner;
      ptr_d   = win_next;
    end
    busy_d = |grant_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      beat_q  <= 2'd0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      beat_q  <= beat_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = owner_q;
  assign bus.beat     = beat_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench for rr_burst_arbiter: vector table, corner sequences
// and randomized requests against a behavioural model (honours ARB_GAP_EN).
module tb_rr_burst_arbiter;

  typedef logic [8:0] obs_t;  // {grant[3:0], grant_id, beat, busy}
  typedef struct {
    logic [3:0] req;
    obs_t       exp;
  } vec_t;
  typedef struct {
    int owner;
    int beat;
    int ptr;
  } model_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   check_count = 0;
  int   pass_count  = 0;

  always #5 clk = ~clk;

  rr_burst_arbiter_if #(.N(4)) bus_a ();
  rr_burst_arbiter_if #(.N(4)) bus_b ();
  rr_burst_arbiter_if #(.N(2)) bus_c ();

  rr_burst_arbiter #(.N(4), .BURST_LEN(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  rr_burst_arbiter #(.N(4), .BURST_LEN(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  rr_burst_arbiter #(.N(2), .BURST_LEN(1)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  function automatic obs_t mkobs(logic [3:0] g, logic [1:0] id, logic [1:0] b);
    return {g, id, b, |g};
  endfunction

  function automatic vec_t mkvec(logic [3:0] r, logic [3:0] g, logic [1:0] id, logic [1:0] b);
    vec_t v;
    v.req = r;
    v.exp = mkobs(g, id, b);
    return v;
  endfunction

  // One clock edge of the arbiter's rules, held as owner index / beat count.
  function automatic model_t model_step(model_t m, logic [3:0] req, int n, int bl);
    model_t r = m;
    int w = -1;
    if (r.owner >= 0) begin
      if (req[r.owner] && r.beat < bl - 1) begin
        r.beat++;
        return r;
      end
      r.owner = -1;
      r.beat  = 0;
`ifdef ARB_GAP_EN
      return r;
`endif
    end
    for (int k = 0; k < n; k++)
      if (w < 0 && req[(r.ptr + k) % n]) w = (r.ptr + k) % n;
    if (w >= 0) begin
      r.owner = w;
      r.beat  = 0;
      r.ptr   = (w + 1) % n;
    end
    return r;
  endfunction

  function automatic obs_t model_obs(model_t m);
    if (m.owner < 0) return '0;
    return mkobs(4'(1) << m.owner, 2'(m.owner), 2'(m.beat));
  endfunction

  function automatic obs_t obs_a();
    return {bus_a.grant, bus_a.grant_id, bus_a.beat, bus_a.busy};
  endfunction
  function automatic obs_t obs_b();
    return {bus_b.grant, bus_b.grant_id, bus_b.beat, bus_b.busy};
  endfunction
  function automatic obs_t obs_c();
    return {2'b00, bus_c.grant, bus_c.grant_id, bus_c.beat, bus_c.busy};
  endfunction

  task automatic check_output(input string name, input obs_t act, input obs_t exp);
    check_count++;
    if (act === exp) pass_count++;
    else
      $display("[TB] FAIL %s: got grant=%b id=%0d beat=%0d busy=%b, expected grant=%b id=%0d beat=%0d busy=%b",
               name, act[8:5], act[4:3], act[2:1], act[0], exp[8:5], exp[4:3], exp[2:1], exp[0]);
  endtask

  task automatic apply_stimulus(input logic [3:0] ra, input logic [3:0] rb, input logic [1:0] rc);
    @(negedge clk);
    bus_a.req = ra;
    bus_b.req = rb;
    bus_c.req = rc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus_a.req = '0;
    bus_b.req = '0;
    bus_c.req = '0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t   vecs[$];
    obs_t   seq_b[$];
    obs_t   seq_c[$];
    model_t ma, mb, mc;
    logic [3:0] ra, rb;
    logic [1:0] rc;

    // Burst table for dut_a (N=4, BURST_LEN=4), starting from reset with ptr=0.
    vecs.push_back(mkvec(4'b0001, 4'b0001, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0001, 4'b0001, 2'd0, 2'd1));
    vecs.push_back(mkvec(4'b0001, 4'b0001, 2'd0, 2'd2));
    vecs.push_back(mkvec(4'b0001, 4'b0001, 2'd0, 2'd3));
`ifdef ARB_GAP_EN
    vecs.push_back(mkvec(4'b0001, 4'b0000, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0001, 4'b0001, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0100, 4'b0000, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0100, 4'b0100, 2'd2, 2'd0));
    vecs.push_back(mkvec(4'b0101, 4'b0100, 2'd2, 2'd1));
    vecs.push_back(mkvec(4'b0001, 4'b0000, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0001, 4'b0001, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0000, 4'b0000, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0000, 4'b0000, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b1000, 4'b1000, 2'd3, 2'd0));
    seq_b = '{mkobs(4'b0001, 2'd0, 2'd0), mkobs(4'b0001, 2'd0, 2'd1), '0,
              mkobs(4'b0010, 2'd1, 2'd0), mkobs(4'b0010, 2'd1, 2'd1), '0,
              mkobs(4'b0100, 2'd2, 2'd0), mkobs(4'b0100, 2'd2, 2'd1), '0,
              mkobs(4'b1000, 2'd3, 2'd0), mkobs(4'b1000, 2'd3, 2'd1), '0,
              mkobs(4'b0001, 2'd0, 2'd0)};
    seq_c = '{mkobs(4'b0001, 2'd0, 2'd0), '0, mkobs(4'b0010, 2'd1, 2'd0), '0,
              mkobs(4'b0001, 2'd0, 2'd0)};
`else
    vecs.push_back(mkvec(4'b0001, 4'b0001, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0100, 4'b0100, 2'd2, 2'd0));
    vecs.push_back(mkvec(4'b0101, 4'b0100, 2'd2, 2'd1));
    vecs.push_back(mkvec(4'b0001, 4'b0001, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0000, 4'b0000, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b0000, 4'b0000, 2'd0, 2'd0));
    vecs.push_back(mkvec(4'b1000, 4'b1000, 2'd3, 2'd0));
    vecs.push_back(mkvec(4'b1010, 4'b1000, 2'd3, 2'd1));
    vecs.push_back(mkvec(4'b0010, 4'b0010, 2'd1, 2'd0));
    vecs.push_back(mkvec(4'b0000, 4'b0000, 2'd0, 2'd0));
    seq_b = '{mkobs(4'b0001, 2'd0, 2'd0), mkobs(4'b0001, 2'd0, 2'd1),
              mkobs(4'b0010, 2'd1, 2'd0), mkobs(4'b0010, 2'd1, 2'd1),
              mkobs(4'b0100, 2'd2, 2'd0), mkobs(4'b0100, 2'd2, 2'd1),
              mkobs(4'b1000, 2'd3, 2'd0), mkobs(4'b1000, 2'd3, 2'd1),
              mkobs(4'b0001, 2'd0, 2'd0)};
    seq_c = '{mkobs(4'b0001, 2'd0, 2'd0), mkobs(4'b0010, 2'd1, 2'd0),
              mkobs(4'b0001, 2'd0, 2'd0)};
`endif

    bus_a.req = '0;
    bus_b.req = '0;
    bus_c.req = '0;

    #12;
    check_output("reset_a", obs_a(), '0);
    check_output("reset_b", obs_b(), '0);
    check_output("reset_c", obs_c(), '0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] idle after reset");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(4'b0000, 4'b0000, 2'b00);
      check_output("idle", obs_a(), '0);
    end

    $display("[TB] vector table");
    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].req, 4'b0000, 2'b00);
      check_output($sformatf("vec%0d", i), obs_a(), vecs[i].exp);
    end

    $display("[TB] reset mid-burst");
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(4'b0001, 4'b0000, 2'b00);
    check_output("pre_reset_beat2", obs_a(), mkobs(4'b0001, 2'd0, 2'd2));
    #2;
    rst = 1'b0;
    #1;
    check_output("async_reset", obs_a(), '0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_output("regrant_after_reset", obs_a(), mkobs(4'b0001, 2'd0, 2'd0));

    $display("[TB] rotation and single-beat alternation");
    do_reset();
    for (int i = 0; i < seq_b.size(); i++) begin
      apply_stimulus(4'b0000, 4'b1111, (i < seq_c.size()) ? 2'b11 : 2'b00);
      check_output($sformatf("rotate%0d", i), obs_b(), seq_b[i]);
      if (i < seq_c.size())
        check_output($sformatf("burst1_%0d", i), obs_c(), seq_c[i]);
    end

    $display("[TB] randomized requests");
    do_reset();
    ma = '{owner: -1, beat: 0, ptr: 0};
    mb = ma;
    mc = ma;
    ra = '0;
    rb = '0;
    rc = '0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) ra = 4'($urandom);
      if ($urandom_range(0, 2) == 0) rb = 4'($urandom);
      if ($urandom_range(0, 1) == 0) rc = 2'($urandom);
      apply_stimulus(ra, rb, rc);
      ma = model_step(ma, ra, 4, 4);
      mb = model_step(mb, rb, 4, 2);
      mc = model_step(mc, {2'b00, rc}, 2, 1);
      check_output("rand_a", obs_a(), model_obs(ma));
      check_output("rand_b", obs_b(), model_obs(mb));
      check_output("rand_c", obs_c(), model_obs(mc));
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
